// File: rtl/airi5c_dmem_arbiter.sv
// Round-robin arbiter between the core LSU and the debug system-bus port for the
// shared data-memory bus: registers the winner, checks alignment, enforces a timeout.
module airi5c_dmem_arbiter #(
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               core_req_i,
  input  logic               core_we_i,
  input  logic [1:0]         core_size_i,
  input  logic [XPR_LEN-1:0] core_addr_i,
  input  logic [XPR_LEN-1:0] core_wdata_i,
  output logic               core_ready_o,
  output logic               core_err_o,
  output logic [XPR_LEN-1:0] core_rdata_o,

  input  logic               dbg_req_i,
  input  logic               dbg_we_i,
  input  logic [1:0]         dbg_size_i,
  input  logic [XPR_LEN-1:0] dbg_addr_i,
  input  logic [XPR_LEN-1:0] dbg_wdata_i,
  output logic               dbg_ready_o,
  output logic               dbg_err_o,
  output logic [XPR_LEN-1:0] dbg_rdata_o,

  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [1:0]         mem_size_o,
  output logic [XPR_LEN-1:0] mem_addr_o,
  output logic [XPR_LEN-1:0] mem_wdata_o,
  input  logic               mem_ready_i,
  input  logic               mem_err_i,
  input  logic [XPR_LEN-1:0] mem_rdata_i,

  output logic [1:0]         grant_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic               prio_dbg;
  logic [7:0]         cnt;
  logic [XPR_LEN-1:0] rdata;

  logic               pick_dbg;
  logic               sel_we;
  logic [1:0]         sel_size;
  logic [XPR_LEN-1:0] sel_addr;
  logic [XPR_LEN-1:0] sel_wdata;
  logic               sel_bad;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_lo[0];
      2'd2:    misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

  // prio_dbg marks which port wins the next tie; it is the opposite of the last winner
  assign pick_dbg  = dbg_req_i & (~core_req_i | prio_dbg);
  assign sel_we    = pick_dbg ? dbg_we_i    : core_we_i;
  assign sel_size  = pick_dbg ? dbg_size_i  : core_size_i;
  assign sel_addr  = pick_dbg ? dbg_addr_i  : core_addr_i;
  assign sel_wdata = pick_dbg ? dbg_wdata_i : core_wdata_i;
  assign sel_bad   = misaligned(sel_size, sel_addr[1:0]);

  assign core_rdata_o = rdata;
  assign dbg_rdata_o  = rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      prio_dbg     <= 1'b0;
      cnt          <= '0;
      rdata        <= '0;
      grant_o      <= '0;
      core_ready_o <= 1'b0;
      core_err_o   <= 1'b0;
      dbg_ready_o  <= 1'b0;
      dbg_err_o    <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_size_o   <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i | dbg_req_i) begin
            mem_we_o    <= sel_we;
            mem_size_o  <= sel_size;
            mem_addr_o  <= sel_addr;
            mem_wdata_o <= sel_wdata;
            grant_o     <= pick_dbg ? 2'b10 : 2'b01;
            if (sel_bad) begin
              // fault locally without touching the bus
              state        <= RESP;
              rdata        <= '0;
              core_ready_o <= ~pick_dbg;
              core_err_o   <= ~pick_dbg;
              dbg_ready_o  <= pick_dbg;
              dbg_err_o    <= pick_dbg;
            end else begin
              state     <= ACCESS;
              mem_req_o <= 1'b1;
              cnt       <= '0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready_i) begin
            state        <= RESP;
            mem_req_o    <= 1'b0;
            rdata        <= mem_we_o ? '0 : mem_rdata_i;
            core_ready_o <= grant_o[0];
            core_err_o   <= grant_o[0] & mem_err_i;
            dbg_ready_o  <= grant_o[1];
            dbg_err_o    <= grant_o[1] & mem_err_i;
          end else if (cnt == TIMEOUT_LAST) begin
            state        <= RESP;
            mem_req_o    <= 1'b0;
            rdata        <= '0;
            core_ready_o <= grant_o[0];
            core_err_o   <= grant_o[0];
            dbg_ready_o  <= grant_o[1];
            dbg_err_o    <= grant_o[1];
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          state        <= IDLE;
          prio_dbg     <= grant_o[0];
          grant_o      <= '0;
          core_ready_o <= 1'b0;
          core_err_o   <= 1'b0;
          dbg_ready_o  <= 1'b0;
          dbg_err_o    <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_airi5c_dmem_arbiter.sv
// Directed bench for airi5c_dmem_arbiter: each step drives inputs after a rising
// edge and checks the registered outputs with hand-computed expectations.
module tb_airi5c_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_ready, core_err;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dbg_req, dbg_we, dbg_ready, dbg_err;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_req, mem_we, mem_ready, mem_err;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  airi5c_dmem_arbiter #(.XPR_LEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_ready_o(core_ready), .core_err_o(core_err), .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_size_i(dbg_size),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ready_o(dbg_ready), .dbg_err_o(dbg_err), .dbg_rdata_o(dbg_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    core_req = 0; core_we = 0; core_size = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_size = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_ready = 0; mem_err = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", 32'({core_ready, dbg_ready}), 0);
    chk("rst_rdata", core_rdata | dbg_rdata, 0);
    rst = 1'b0;

    // core word load, zero wait
    core_req = 1; core_we = 0; core_size = 2; core_addr = 32'h100;
    tick();
    chk("ld_mem_req", 32'(mem_req), 1);
    chk("ld_mem_addr", mem_addr, 32'h100);
    chk("ld_grant", 32'(grant), 32'b01);
    chk("ld_ready_early", 32'(core_ready), 0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF; core_req = 0;
    tick();
    chk("ld_ready", 32'(core_ready), 1);
    chk("ld_rdata", core_rdata, 32'hDEADBEEF);
    chk("ld_err", 32'(core_err), 0);
    chk("ld_mem_req_drop", 32'(mem_req), 0);
    mem_ready = 0;
    tick();
    chk("ld_idle_ready", 32'(core_ready), 0);
    chk("ld_idle_grant", 32'(grant), 0);
    chk("ld_addr_hold", mem_addr, 32'h100);

    // debug write timeout after 4 cycles
    dbg_req = 1; dbg_we = 1; dbg_size = 2; dbg_addr = 32'h400; dbg_wdata = 32'h55;
    tick();
    dbg_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_mem_req_%0d", i), 32'(mem_req), 1);
      tick();
    end
    chk("to_mem_req_drop", 32'(mem_req), 0);
    chk("to_ready", 32'(dbg_ready), 1);
    chk("to_err", 32'(dbg_err), 1);
    chk("to_rdata", dbg_rdata, 0);
    chk("to_core_quiet", 32'(core_ready), 0);
    tick();

    // misaligned half access
    core_req = 1; core_we = 0; core_size = 1; core_addr = 32'h103;
    tick();
    core_req = 0;
    chk("mis_ready", 32'(core_ready), 1);
    chk("mis_err", 32'(core_err), 1);
    chk("mis_mem_req", 32'(mem_req), 0);
    tick();
    chk("mis_idle", 32'(core_ready), 0);

    // illegal size on the debug port
    dbg_req = 1; dbg_we = 0; dbg_size = 3; dbg_addr = 32'h0;
    tick();
    dbg_req = 0;
    chk("ill_ready", 32'(dbg_ready), 1);
    chk("ill_err", 32'(dbg_err), 1);
    chk("ill_mem_req", 32'(mem_req), 0);
    tick();

    // aligned half write with bus error; writes return zero data
    core_req = 1; core_we = 1; core_size = 1; core_addr = 32'h102; core_wdata = 32'hABCD;
    tick();
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_size", 32'(mem_size), 1);
    chk("wr_mem_wdata", mem_wdata, 32'hABCD);
    mem_ready = 1; mem_err = 1; mem_rdata = 32'hFFFFFFFF; core_req = 0;
    tick();
    chk("wr_ready", 32'(core_ready), 1);
    chk("wr_err", 32'(core_err), 1);
    chk("wr_rdata", core_rdata, 0);
    mem_ready = 0; mem_err = 0;
    tick();

    // simultaneous requests after reset, two wait states each
    rst = 1; tick(); rst = 0;
    core_req = 1; core_we = 0; core_size = 2; core_addr = 32'h200;
    dbg_req = 1; dbg_we = 0; dbg_size = 2; dbg_addr = 32'h300;
    tick();
    chk("tie1_grant", 32'(grant), 32'b01);
    chk("tie1_addr", mem_addr, 32'h200);
    tick(); tick();
    chk("tie1_wait_req", 32'(mem_req), 1);
    chk("tie1_wait_ready", 32'(core_ready), 0);
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    mem_ready = 0;
    chk("tie1_ready", 32'(core_ready), 1);
    chk("tie1_rdata", core_rdata, 32'h11111111);
    chk("tie1_dbg_quiet", 32'(dbg_ready), 0);
    tick();
    chk("tie1_idle_grant", 32'(grant), 0);
    tick();
    chk("tie2_grant", 32'(grant), 32'b10);
    chk("tie2_addr", mem_addr, 32'h300);
    tick(); tick();
    mem_ready = 1; mem_rdata = 32'h22222222;
    tick();
    mem_ready = 0;
    chk("tie2_ready", 32'(dbg_ready), 1);
    chk("tie2_rdata", dbg_rdata, 32'h22222222);
    tick();
    tick();
    chk("tie3_grant", 32'(grant), 32'b01);
    core_req = 0; dbg_req = 0;
    mem_ready = 1; mem_rdata = 32'h33333333;
    tick();
    mem_ready = 0;
    chk("tie3_ready", 32'(core_ready), 1);
    tick();

    // reset during an access
    core_req = 1; core_addr = 32'h500; core_size = 2; core_we = 0;
    tick();
    chk("rm_mem_req", 32'(mem_req), 1);
    rst = 1; core_req = 0;
    tick();
    rst = 0;
    chk("rm_mem_req_drop", 32'(mem_req), 0);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_mem_addr", mem_addr, 0);
    chk("rm_rdata", core_rdata, 0);
    tick();
    chk("rm_no_ready", 32'({core_ready, dbg_ready}), 0);
    core_req = 1; dbg_req = 1; core_addr = 32'h600; dbg_addr = 32'h700;
    tick();
    chk("rm_tie_grant", 32'(grant), 32'b01);
    core_req = 0; dbg_req = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
